// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of buffered core stores draining to memory.
//
// Ports:
//   clk, rst              single clock; asynchronous active-low reset
//   memwrite/address/data core store request; stall=1 when it cannot be taken
//   mem_wvalid/waddr/wdata head entry offered to memory (straight from storage)
//   mem_wready            memory accepts the head entry this cycle
//   empty                 no buffered stores remain
//   raddr/fwd_hit/fwd_data load-forwarding lookup (doubleword granularity)
//
// Optional feature: define STORE_BUF_FWD_EN to build the forwarding comparators.
// Without it fwd_hit/fwd_data are tied to zero and raddr is unused.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [63:0] address,
  input  logic [63:0] data,
  output logic        stall,
  output logic        mem_wvalid,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  input  logic        mem_wready,
  output logic        empty,
  input  logic [63:0] raddr,
  output logic        fwd_hit,
  output logic [63:0] fwd_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [63:0]      addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic full;
  logic enq;
  logic deq;

  assign full  = (count_q == CW'(DEPTH));
  // A stalled store is never taken, even when the head drains this cycle.
  assign enq   = memwrite && !full;
  assign deq   = (count_q != '0) && mem_wready;
  assign stall = memwrite && full;

  assign mem_wvalid = (count_q != '0);
  assign empty      = (count_q == '0);
  assign mem_waddr  = addr_q[head_q];
  assign mem_wdata  = data_q[head_q];

  // Storage carries no reset; validity is tracked by count/valid_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= address;
      data_q[tail_q] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (deq) begin
        head_q          <= head_q + 1'b1;
        valid_q[head_q] <= 1'b0;
      end
      if (enq) begin
        tail_q          <= tail_q + 1'b1;
        valid_q[tail_q] <= 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef STORE_BUF_FWD_EN
  // Walk entries oldest to youngest starting at head so the last match wins.
  // The head being drained this cycle is still valid and thus searched; the
  // store being enqueued this cycle is not yet in storage and thus excluded.
  logic [PW-1:0] idx;
  logic          unused_raddr_lo;

  assign unused_raddr_lo = ^raddr[2:0];

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx][63:3] == raddr[63:3])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end
`else
  logic unused_raddr;

  assign unused_raddr = ^raddr;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic [63:0] address;
  logic [63:0] data;
  logic        stall;
  logic        mem_wvalid;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic        mem_wready;
  logic        empty;
  logic [63:0] raddr;
  logic        fwd_hit;
  logic [63:0] fwd_data;

  int checks   = 0;
  int failures = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .memwrite   (memwrite),
    .address    (address),
    .data       (data),
    .stall      (stall),
    .mem_wvalid (mem_wvalid),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wready (mem_wready),
    .empty      (empty),
    .raddr      (raddr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mw;
    int   id;
    logic rdy;
    logic e_stall;
    logic e_valid;
    int   e_head;   // -1: head contents not checked
    logic e_empty;
  } vec_t;

  vec_t vec[$];

  function automatic logic [63:0] addr_of(input int id);
    return 64'h0000_0000_8000_1000 + 64'(id) * 64'd8;
  endfunction

  function automatic logic [63:0] data_of(input int id);
    return {32'hDA7A_0000, 32'(id) ^ 32'h5A5A_0000};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic mw, input int id, input logic rdy,
                     input logic e_stall, input logic e_valid, input int e_head,
                     input logic e_empty);
    vec.push_back('{mw, id, rdy, e_stall, e_valid, e_head, e_empty});
  endtask

  task automatic drive(input logic mw, input int id, input logic rdy);
    memwrite   = mw;
    address    = addr_of(id);
    data       = data_of(id);
    mem_wready = rdy;
  endtask

  initial begin
    // fill / stall on 5th / drain in order
    add(1, 0, 0, 0, 0, -1, 1);
    add(1, 1, 0, 0, 1, 0, 0);
    add(1, 2, 0, 0, 1, 0, 0);
    add(1, 3, 0, 0, 1, 0, 0);
    add(1, 4, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 1, 2, 0);
    add(0, 0, 1, 0, 1, 3, 0);
    add(0, 0, 1, 0, 0, -1, 1);
    // full with simultaneous dequeue: stalled store accepted next cycle
    add(1, 10, 0, 0, 0, -1, 1);
    add(1, 11, 0, 0, 1, 10, 0);
    add(1, 12, 0, 0, 1, 10, 0);
    add(1, 13, 0, 0, 1, 10, 0);
    add(1, 14, 1, 1, 1, 10, 0);
    add(1, 14, 0, 0, 1, 11, 0);
    add(1, 15, 0, 1, 1, 11, 0);
    add(0, 0, 1, 0, 1, 11, 0);
    add(0, 0, 1, 0, 1, 12, 0);
    add(0, 0, 1, 0, 1, 13, 0);
    add(0, 0, 1, 0, 1, 14, 0);
    add(0, 0, 0, 0, 0, -1, 1);
    // backpressure, enqueue+dequeue together, wready while empty
    add(1, 20, 0, 0, 0, -1, 1);
    add(1, 21, 1, 0, 1, 20, 0);
    add(1, 22, 0, 0, 1, 21, 0);
    add(0, 0, 0, 0, 1, 21, 0);
    add(0, 0, 1, 0, 1, 21, 0);
    add(0, 0, 0, 0, 1, 22, 0);
    add(0, 0, 1, 0, 1, 22, 0);
    add(0, 0, 1, 0, 0, -1, 1);
    add(0, 0, 0, 0, 0, -1, 1);

    // reset state
    rst = 1'b0;
    memwrite = 1'b1; address = '0; data = '0; mem_wready = 1'b1; raddr = '0;
    #3;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_wvalid", 64'(mem_wvalid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_data", fwd_data, 64'd0);
    memwrite = 1'b0;
    #9 rst = 1'b1;
    tick();

    // single store
    memwrite = 1'b1; address = 64'h8000_1000; data = 64'h1122_3344_5566_7788; mem_wready = 1'b1;
    @(negedge clk);
    chk("single_empty0", 64'(empty), 64'd1);
    tick();
    memwrite = 1'b0;
    @(negedge clk);
    chk("single_wvalid", 64'(mem_wvalid), 64'd1);
    chk("single_waddr", mem_waddr, 64'h8000_1000);
    chk("single_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    tick();
    mem_wready = 1'b0;
    @(negedge clk);
    chk("single_empty1", 64'(empty), 64'd1);
    tick();

    // vector table
    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].mw, vec[i].id, vec[i].rdy);
      raddr = '0;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'(vec[i].e_stall));
      chk($sformatf("v%0d_wvalid", i), 64'(mem_wvalid), 64'(vec[i].e_valid));
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vec[i].e_empty));
      chk($sformatf("v%0d_fwd_hit", i), 64'(fwd_hit), 64'd0);
      if (vec[i].e_head >= 0) begin
        chk($sformatf("v%0d_waddr", i), mem_waddr, addr_of(vec[i].e_head));
        chk($sformatf("v%0d_wdata", i), mem_wdata, data_of(vec[i].e_head));
      end
      tick();
    end

    // reset mid-operation
    drive(1, 30, 0); tick();
    drive(1, 31, 0); tick();
    drive(1, 32, 0); tick();
    drive(1, 33, 0);
    chk("pre_rst_wvalid", 64'(mem_wvalid), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_wvalid", 64'(mem_wvalid), 64'd0);
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_stall", 64'(stall), 64'd0);
    drive(0, 0, 1);
    #3 rst = 1'b1;
    tick();
    @(negedge clk);
    chk("postrst_wvalid", 64'(mem_wvalid), 64'd0);
    chk("postrst_empty", 64'(empty), 64'd1);
    tick();
    // store accepted on first edge after release
    rst = 1'b0;
    drive(1, 34, 0);
    #3 rst = 1'b1;
    tick();
    drive(0, 0, 0);
    @(negedge clk);
    chk("firstedge_wvalid", 64'(mem_wvalid), 64'd1);
    chk("firstedge_waddr", mem_waddr, addr_of(34));
    chk("firstedge_wdata", mem_wdata, data_of(34));
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    @(negedge clk);
    chk("firstedge_drained", 64'(empty), 64'd1);
    tick();

    // forwarding
    memwrite = 1'b1; address = 64'h8000_2000; data = 64'hA; mem_wready = 1'b0;
    raddr = 64'h8000_2000;
    @(negedge clk);
    chk("fwd_enq_excluded", 64'(fwd_hit), 64'd0);
    tick();
    data = 64'hB; raddr = 64'h8000_2004;
`ifdef STORE_BUF_FWD_EN
    @(negedge clk);
    chk("fwd_one_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_one_data", fwd_data, 64'hA);
`endif
    tick();
    memwrite = 1'b0;
    @(negedge clk);
`ifdef STORE_BUF_FWD_EN
    chk("fwd_young_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_young_data", fwd_data, 64'hB);
`else
    chk("nofwd_hit", 64'(fwd_hit), 64'd0);
    chk("nofwd_data", fwd_data, 64'd0);
`endif
    raddr = 64'h8000_2008;
    #1;
    chk("fwd_miss_hit", 64'(fwd_hit), 64'd0);
    chk("fwd_miss_data", fwd_data, 64'd0);
    raddr = 64'h8000_2004; mem_wready = 1'b1;
    tick();
    @(negedge clk);
    // only B remains and is being dequeued this cycle
`ifdef STORE_BUF_FWD_EN
    chk("fwd_deq_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_deq_data", fwd_data, 64'hB);
`else
    chk("nofwd_deq_hit", 64'(fwd_hit), 64'd0);
`endif
    chk("fwd_deq_waddr", mem_waddr, 64'h8000_2000);
    tick();
    @(negedge clk);
    chk("fwd_final_hit", 64'(fwd_hit), 64'd0);
    chk("fwd_final_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port memwrite  input  1  core store request this cycle.
REQ-005 SHALL have port address  input  64  core store address.
REQ-006 SHALL have port data  input  64  core store data (doubleword).
REQ-007 SHALL have port stall  output  1  store not accepted; core holds pc and inst.
REQ-008 SHALL have port mem_wvalid  output  1  head entry offered to memory.
REQ-009 SHALL have port mem_waddr  output  64  head entry address.
REQ-010 SHALL have port mem_wdata  output  64  head entry data.
REQ-011 SHALL have port mem_wready  input  1  memory accepts head entry.
REQ-012 SHALL have port empty  output  1  no buffered stores; core may finish on ebreak only when 1.
REQ-013 SHALL have port raddr  input  64  load address for forwarding lookup.
REQ-014 SHALL have port fwd_hit  output  1  buffered store matches raddr.
REQ-015 SHALL have port fwd_data  output  64  data of youngest matching entry.

Function
REQ-016 SHALL be a circular FIFO of DEPTH {address,data} entries with head/tail pointers wrapping modulo DEPTH and a count of width clog2(DEPTH+1).
REQ-017 SHALL enqueue at tail on the clock edge when memwrite=1 and count<DEPTH.
REQ-018 SHALL drive stall=1 combinationally when memwrite=1 and count==DEPTH, else 0; a stalled store SHALL not be enqueued, even if a dequeue occurs that cycle (no same-cycle pass-through).
REQ-019 SHALL drive mem_wvalid=(count!=0), mem_waddr/mem_wdata from head entry directly from storage (zero added latency).
REQ-020 SHALL dequeue head on the edge when mem_wvalid=1 and mem_wready=1; mem_waddr/mem_wdata SHALL stay stable while mem_wvalid=1 and mem_wready=0.
REQ-021 SHALL, on simultaneous enqueue and dequeue, keep count unchanged and advance both pointers.
REQ-022 SHALL never dequeue when empty; mem_wready while empty SHALL be ignored.
REQ-023 SHALL drive empty=(count==0).
REQ-024 SHALL write stores to memory in enqueue order, each exactly once.
REQ-025 SHALL compute fwd_hit combinationally: valid entry with address[63:3]==raddr[63:3]; fwd_data SHALL be youngest such entry, 0 when no hit.
REQ-026 SHALL include in lookup the head entry being dequeued this cycle; SHALL exclude the store being enqueued this cycle.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear head, tail, count and per-entry valid bits.
REQ-028 SHALL hold outputs in reset: stall=0, mem_wvalid=0, empty=1, fwd_hit=0, fwd_data=0; mem_waddr/mem_wdata don't-care.
REQ-029 SHALL discard pending stores on reset asserted mid-operation; storage arrays need not be reset.
REQ-030 SHALL accept a store on the first rising edge after rst deasserts.

Configuration
REQ-031 SHALL, with STORE_BUF_FWD_EN defined, implement REQ-025/026 forwarding logic.
REQ-032 SHALL, without STORE_BUF_FWD_EN, tie fwd_hit=0 and fwd_data=0, omit comparators, and leave raddr unused; FIFO behaviour unchanged.

Verification
REQ-033 SHALL cover single store: memwrite=1, address=0x80001000, data=0x1122334455667788, mem_wready=1 -> next cycle mem_wvalid=1 with those values, following cycle empty=1.
REQ-034 SHALL cover fill/stall: mem_wready=0, 5 consecutive stores, DEPTH=4 -> stall=1 on 5th only, count=4, 5th not enqueued; mem_wready=1 then -> four writes in order.
REQ-035 SHALL cover full with simultaneous dequeue: count=4, memwrite=1, mem_wready=1 -> stall=1, count=3 after edge, stalled store enqueued next cycle.
REQ-036 SHALL cover backpressure: mem_wready toggles 0,1 -> mem_waddr/mem_wdata stable while held, no duplicates, no losses.
REQ-037 SHALL cover forwarding (macro defined): stores 0x80002000<-0xA, 0x80002000<-0xB held, raddr=0x80002004 -> fwd_hit=1, fwd_data=0xB; raddr=0x80002008 -> fwd_hit=0; macro undefined -> fwd_hit=0 always.
REQ-038 SHALL cover reset mid-operation: 3 pending stores, rst=0 asynchronously mid-cycle -> immediately mem_wvalid=0, empty=1; no stale write after release.
